ppu_mem_responder: RTL and testbench
====================================

# ppu_mem_responder

Memory-side responder for the PixelProcessingUnit's two read-request interfaces: the VRAM fetch port (addr/addr_valid → data/data_valid) and the OAM scan port (oam_addr/oam_addr_valid → oam_data/oam_data_valid). It owns the 8 KiB VRAM and the 160 B OAM arrays. It answers PPU reads with a fixed, pipelined latency and provides a CPU-side read/write port gated by PPU mode. It sits between the PPU and the future CPU bus in fpgaboy and replaces the constant data tie-offs currently driven at top level.

## Interface
- READ_LATENCY, default 2: cycles from request sample to data_valid pulse; legal values 1–3.
- clk_in  input  1  system clock (100 MHz domain)
- rst_in  input  1  asynchronous, active-low reset
- mode_in  input  2  current PPU mode (0 HBlank, 1 VBlank, 2 OAM scan, 3 drawing)
- ppu_addr_in  input  16  PPU VRAM fetch address
- ppu_addr_valid_in  input  1  PPU VRAM request strobe, sampled every cycle
- ppu_data_out  output  8  VRAM read data
- ppu_data_valid_out  output  1  one-cycle pulse per answered VRAM request
- oam_addr_in  input  16  PPU OAM fetch address
- oam_addr_valid_in  input  1  PPU OAM request strobe
- oam_data_out  output  8  OAM read data
- oam_data_valid_out  output  1  one-cycle pulse per answered OAM request
- cpu_addr_in  input  16  CPU address
- cpu_rd_in  input  1  CPU read strobe
- cpu_wr_in  input  1  CPU write strobe
- cpu_data_in  input  8  CPU write data
- cpu_data_out  output  8  CPU read data
- cpu_data_valid_out  output  1  one-cycle pulse per answered CPU read
- blocked_wr_count_out  output  16  saturating count of CPU writes dropped by mode lock

## Operation
- VRAM is $8000–$9FFF, indexed by addr[12:0]. OAM is $FE00–$FE9F, indexed by addr[7:0], and is valid only when the index is < 160.
- Each array is a true dual-port RAM with registered reads. Port A is the PPU (VRAM: ppu port; OAM: oam port). Port B is the CPU.
- PPU ports are fully pipelined with no stall. Every cycle with valid high is one request, and every request gets exactly one response, in order.
- Out-of-range PPU address: the response carries 8'hFF with the normal latency and valid pulse.
- The PPU ports ignore mode_in. The PPU is always served.
- CPU lock is evaluated with the mode_in value sampled in the request cycle:
  - VRAM is locked when mode is 3.
  - OAM is locked when mode is 2 or 3.
  - Addresses outside both windows are treated as unmapped.
- CPU write: applied at the sampling edge if the target is unlocked and mapped. A write to a locked target is dropped and increments blocked_wr_count_out, which saturates at 16'hFFFF. An unmapped write is dropped silently.
- CPU read: returns array data if the target is unlocked and mapped, otherwise 8'hFF. The valid pulse is always produced.
- cpu_rd_in and cpu_wr_in high together: the write is performed and no read response is produced.
- Same address, same cycle, CPU write and PPU read: the PPU receives the old data (read-first). The new data is visible to requests from the next cycle on.

## Timing
- Reset (rst_in low, asynchronous):
  - All data outputs go to 8'h00 and all valid outputs go to 0.
  - blocked_wr_count_out goes to 0.
  - All in-flight pipeline entries are discarded.
  - RAM contents are not cleared.
- Reset mid-operation: responses to requests accepted before the reset edge are never emitted. After reset deasserts, the first request is sampled on the first rising edge.
- Latency: a request sampled at rising edge k has its data_valid high and data stable for exactly the cycle following edge k+READ_LATENCY−1 registration, i.e. valid at edge k+READ_LATENCY. It is low otherwise.
- Data outputs hold their last value when valid is low.
- Throughput: one request per port per cycle. All three ports operate concurrently and independently.
- Mode changes take effect per request. A request sampled before a mode change keeps its lock decision.

## Test plan
- VRAM latency and ordering:
  - Stimulus: CPU writes $8000=8'h11, $8001=8'h22 and $9FFF=8'h33 in mode 0, then the PPU holds valid for 3 consecutive cycles with addresses $8000, $8001, $9FFF.
  - Required response: ppu_data_valid_out is high for 3 consecutive cycles starting READ_LATENCY cycles after the first request, with data 8'h11, 8'h22, 8'h33.
- OAM bounds:
  - Stimulus: OAM reads at $FE9F and $FEA0 after a CPU write of 8'h5A to $FE9F in mode 1.
  - Required response: 8'h5A, then 8'hFF, both with a valid pulse.
- Mode lock:
  - Stimulus: in mode 3, CPU writes 8'hAA to $8010 and to $FE10, then reads $8010.
  - Required response: both writes are dropped, blocked_wr_count_out=2, and the read returns 8'hFF with a valid pulse.
  - Then: in mode 0, a CPU read of $8010 returns the old contents.
- Read-first collision:
  - Stimulus: $8100 holds 8'h01. In the same cycle, the CPU writes 8'h02 to $8100 and the PPU reads $8100; the PPU reads it again the next cycle.
  - Required response: 8'h01, then 8'h02.
- Reset mid-flight:
  - Stimulus: PPU requests are issued on 2 consecutive cycles, and rst_in is pulled low 1 cycle later.
  - Required response: valids drop immediately, and no response is emitted after release.
  - blocked_wr_count_out=0 and RAM contents are preserved. Check this by reading a previously written address.
- Saturation and simultaneous strobes:
  - Stimulus: force the counter near 16'hFFFF via 65 540 locked writes. Separately, assert cpu_rd_in and cpu_wr_in together on an unlocked address.
  - Required response: the counter saturates at 16'hFFFF. With both strobes high, the write lands and cpu_data_valid_out stays low.

Source files
------------

// File: rtl/ppu_mem_responder.sv
// ppu_mem_responder: owns VRAM (8 KiB) and OAM (160 B) and answers PPU fetches
// with a fixed pipelined latency. It also serves a CPU read/write port that is
// locked by the PPU mode.

// Response delay line. Data advances only with its valid bit, so the last
// stage holds the previous answer while no response is flowing.
module ppu_mem_responder_pipe #(
    parameter int LAT = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       vld_i,
    input  logic [7:0] dat_i,
    output logic       vld_o,
    output logic [7:0] dat_o
);
    logic [LAT:1]      vld_q;
    logic [LAT:1][7:0] dat_q;
    logic [LAT:0]      vchain;
    logic [LAT:0][7:0] dchain;

    assign vchain = {vld_q, vld_i};
    assign dchain = {dat_q, dat_i};
    assign vld_o  = vchain[LAT];
    assign dat_o  = dchain[LAT];

    // Shift valid every cycle, and move data only alongside a valid bit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= '0;
            dat_q <= '0;
        end else begin
            for (int i = 1; i <= LAT; i++) begin
                vld_q[i] <= vchain[i-1];
                if (vchain[i-1]) dat_q[i] <= dchain[i-1];
            end
        end
    end
endmodule

module ppu_mem_responder #(
    parameter int READ_LATENCY = 2  // legal range 1..3
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [1:0]  mode_in,
    input  logic [15:0] ppu_addr_in,
    input  logic        ppu_addr_valid_in,
    output logic [7:0]  ppu_data_out,
    output logic        ppu_data_valid_out,
    input  logic [15:0] oam_addr_in,
    input  logic        oam_addr_valid_in,
    output logic [7:0]  oam_data_out,
    output logic        oam_data_valid_out,
    input  logic [15:0] cpu_addr_in,
    input  logic        cpu_rd_in,
    input  logic        cpu_wr_in,
    input  logic [7:0]  cpu_data_in,
    output logic [7:0]  cpu_data_out,
    output logic        cpu_data_valid_out,
    output logic [15:0] blocked_wr_count_out
);
    localparam int VRAM_DEPTH = 8192;
    localparam int OAM_DEPTH  = 160;

    logic [7:0] vram_q [VRAM_DEPTH];
    logic [7:0] oam_q  [OAM_DEPTH];

    // Registered read data, one register per port of each array.
    logic [7:0] vram_a_q, vram_b_q, oam_a_q, oam_b_q;

    // First pipeline stage: request attributes captured alongside the RAM read.
    logic ppu_vld_q, ppu_oob_q, oam_vld_q, oam_oob_q;
    logic cpu_vld_q, cpu_ff_q, cpu_sel_oam_q;

    logic [15:0] blocked_cnt_q, blocked_cnt_d;

    // Address decode and mode lock, all taken from the current request cycle.
    logic ppu_vram_hit, ppu_oam_hit, cpu_vram_hit, cpu_oam_hit;
    logic cpu_mapped, cpu_locked, cpu_wr_ok;

    assign ppu_vram_hit = (ppu_addr_in[15:13] == 3'b100);
    assign ppu_oam_hit  = (oam_addr_in[15:8] == 8'hFE) && (oam_addr_in[7:0] < 8'd160);
    assign cpu_vram_hit = (cpu_addr_in[15:13] == 3'b100);
    assign cpu_oam_hit  = (cpu_addr_in[15:8] == 8'hFE) && (cpu_addr_in[7:0] < 8'd160);
    assign cpu_mapped   = cpu_vram_hit || cpu_oam_hit;
    // VRAM is locked only while drawing; OAM also during OAM scan.
    assign cpu_locked   = (cpu_vram_hit && (mode_in == 2'd3)) ||
                          (cpu_oam_hit && mode_in[1]);
    assign cpu_wr_ok    = cpu_wr_in && cpu_mapped && !cpu_locked;

    // VRAM port A: PPU read only; read-first against the CPU write below.
    always_ff @(posedge clk_in) begin
        vram_a_q <= vram_q[ppu_addr_in[12:0]];
    end

    // VRAM port B: CPU write and registered read.
    always_ff @(posedge clk_in) begin
        if (cpu_wr_ok && cpu_vram_hit) vram_q[cpu_addr_in[12:0]] <= cpu_data_in;
        vram_b_q <= vram_q[cpu_addr_in[12:0]];
    end

    // OAM port A: PPU read; indices past 159 are never looked up.
    always_ff @(posedge clk_in) begin
        if (ppu_oam_hit) oam_a_q <= oam_q[oam_addr_in[7:0]];
    end

    // OAM port B: CPU write and registered read.
    always_ff @(posedge clk_in) begin
        if (cpu_wr_ok && cpu_oam_hit) oam_q[cpu_addr_in[7:0]] <= cpu_data_in;
        if (cpu_oam_hit) oam_b_q <= oam_q[cpu_addr_in[7:0]];
    end

    // Capture per-request control next to the RAM read; the lock decision is
    // frozen here, so later mode changes cannot affect this request.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            ppu_vld_q     <= 1'b0;
            ppu_oob_q     <= 1'b0;
            oam_vld_q     <= 1'b0;
            oam_oob_q     <= 1'b0;
            cpu_vld_q     <= 1'b0;
            cpu_ff_q      <= 1'b0;
            cpu_sel_oam_q <= 1'b0;
        end else begin
            ppu_vld_q     <= ppu_addr_valid_in;
            ppu_oob_q     <= !ppu_vram_hit;
            oam_vld_q     <= oam_addr_valid_in;
            oam_oob_q     <= !ppu_oam_hit;
            cpu_vld_q     <= cpu_rd_in && !cpu_wr_in;
            cpu_ff_q      <= !cpu_mapped || cpu_locked;
            cpu_sel_oam_q <= cpu_oam_hit;
        end
    end

    // Saturating count of writes dropped because of the mode lock.
    always_comb begin
        blocked_cnt_d = blocked_cnt_q;
        if (cpu_wr_in && cpu_locked && (blocked_cnt_q != 16'hFFFF))
            blocked_cnt_d = blocked_cnt_q + 16'd1;
    end

    // Counter register.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) blocked_cnt_q <= '0;
        else         blocked_cnt_q <= blocked_cnt_d;
    end

    assign blocked_wr_count_out = blocked_cnt_q;

    logic [7:0] ppu_dat0, oam_dat0, cpu_dat0;
    assign ppu_dat0 = ppu_oob_q ? 8'hFF : vram_a_q;
    assign oam_dat0 = oam_oob_q ? 8'hFF : oam_a_q;
    assign cpu_dat0 = cpu_ff_q ? 8'hFF : (cpu_sel_oam_q ? oam_b_q : vram_b_q);

    ppu_mem_responder_pipe #(.LAT(READ_LATENCY)) u_ppu_pipe (
        .clk_i(clk_in), .rst_ni(rst_in), .vld_i(ppu_vld_q), .dat_i(ppu_dat0),
        .vld_o(ppu_data_valid_out), .dat_o(ppu_data_out)
    );

    ppu_mem_responder_pipe #(.LAT(READ_LATENCY)) u_oam_pipe (
        .clk_i(clk_in), .rst_ni(rst_in), .vld_i(oam_vld_q), .dat_i(oam_dat0),
        .vld_o(oam_data_valid_out), .dat_o(oam_data_out)
    );

    ppu_mem_responder_pipe #(.LAT(READ_LATENCY)) u_cpu_pipe (
        .clk_i(clk_in), .rst_ni(rst_in), .vld_i(cpu_vld_q), .dat_i(cpu_dat0),
        .vld_o(cpu_data_valid_out), .dat_o(cpu_data_out)
    );
endmodule

// File: tb/tb_ppu_mem_responder.sv
// Directed bench for ppu_mem_responder: table of single transactions plus
// hand-written multi-cycle sequences (ordering, collision, reset, saturation).
module tb_ppu_mem_responder;
    localparam int L = 2;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [1:0]  mode_in;
    logic [15:0] ppu_addr_in, oam_addr_in, cpu_addr_in;
    logic        ppu_addr_valid_in, oam_addr_valid_in, cpu_rd_in, cpu_wr_in;
    logic [7:0]  cpu_data_in;
    logic [7:0]  ppu_data_out, oam_data_out, cpu_data_out;
    logic        ppu_data_valid_out, oam_data_valid_out, cpu_data_valid_out;
    logic [15:0] blocked_wr_count_out;

    int checks = 0;
    int failures = 0;

    ppu_mem_responder #(.READ_LATENCY(L)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .mode_in(mode_in),
        .ppu_addr_in(ppu_addr_in), .ppu_addr_valid_in(ppu_addr_valid_in),
        .ppu_data_out(ppu_data_out), .ppu_data_valid_out(ppu_data_valid_out),
        .oam_addr_in(oam_addr_in), .oam_addr_valid_in(oam_addr_valid_in),
        .oam_data_out(oam_data_out), .oam_data_valid_out(oam_data_valid_out),
        .cpu_addr_in(cpu_addr_in), .cpu_rd_in(cpu_rd_in), .cpu_wr_in(cpu_wr_in),
        .cpu_data_in(cpu_data_in), .cpu_data_out(cpu_data_out),
        .cpu_data_valid_out(cpu_data_valid_out),
        .blocked_wr_count_out(blocked_wr_count_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] ca;
        logic        rd;
        logic        wr;
        logic [7:0]  wd;
        logic        pv;
        logic [15:0] pa;
        logic        ov;
        logic [15:0] oa;
        logic [7:0]  epd;
        logic [7:0]  eod;
        logic [7:0]  ecd;
        logic [15:0] ecnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic [1:0] mode, logic [15:0] ca, logic rd, logic wr,
                                logic [7:0] wd, logic pv, logic [15:0] pa, logic ov,
                                logic [15:0] oa, logic [7:0] epd, logic [7:0] eod,
                                logic [7:0] ecd, logic [15:0] ecnt);
        vec_t v;
        v.mode = mode; v.ca = ca; v.rd = rd; v.wr = wr; v.wd = wd;
        v.pv = pv; v.pa = pa; v.ov = ov; v.oa = oa;
        v.epd = epd; v.eod = eod; v.ecd = ecd; v.ecnt = ecnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        ppu_addr_valid_in = 1'b0; oam_addr_valid_in = 1'b0;
        cpu_rd_in = 1'b0; cpu_wr_in = 1'b0;
    endtask

    task automatic chk_valids(input string tag, input logic ep, input logic eo, input logic ec);
        chk({tag, " ppu_valid"}, 32'(ppu_data_valid_out), 32'(ep));
        chk({tag, " oam_valid"}, 32'(oam_data_valid_out), 32'(eo));
        chk({tag, " cpu_valid"}, 32'(cpu_data_valid_out), 32'(ec));
    endtask

    // One transaction: valid pulse exactly at edge k+L, data held afterwards.
    task automatic apply(input int idx, input vec_t v);
        string tag;
        logic  ecv;
        tag = $sformatf("row%0d", idx);
        ecv = v.rd && !v.wr;
        mode_in = v.mode; cpu_addr_in = v.ca; cpu_rd_in = v.rd; cpu_wr_in = v.wr;
        cpu_data_in = v.wd; ppu_addr_valid_in = v.pv; ppu_addr_in = v.pa;
        oam_addr_valid_in = v.ov; oam_addr_in = v.oa;
        step();
        idle();
        for (int c = 1; c <= L + 1; c++) begin
            step();
            if (c == L) chk_valids(tag, v.pv, v.ov, ecv);
            else        chk_valids(tag, 1'b0, 1'b0, 1'b0);
            if (c >= L) begin
                if (v.pv) chk({tag, " ppu_data"}, 32'(ppu_data_out), 32'(v.epd));
                if (v.ov) chk({tag, " oam_data"}, 32'(oam_data_out), 32'(v.eod));
                if (ecv)  chk({tag, " cpu_data"}, 32'(cpu_data_out), 32'(v.ecd));
            end
        end
        chk({tag, " blocked_cnt"}, 32'(blocked_wr_count_out), 32'(v.ecnt));
    endtask

    initial begin
        logic [15:0] seq_a [3];
        logic [7:0]  seq_d [3];

        rst_in = 1'b1; mode_in = 2'd0;
        ppu_addr_in = '0; oam_addr_in = '0; cpu_addr_in = '0; cpu_data_in = '0;
        idle();
        #2 rst_in = 1'b0;
        #1;
        chk_valids("reset", 1'b0, 1'b0, 1'b0);
        chk("reset ppu_data", 32'(ppu_data_out), 32'h0);
        chk("reset oam_data", 32'(oam_data_out), 32'h0);
        chk("reset cpu_data", 32'(cpu_data_out), 32'h0);
        chk("reset blocked_cnt", 32'(blocked_wr_count_out), 32'h0);
        #19 rst_in = 1'b1;

        //            mode ca       rd wr wd     pv pa        ov oa        epd    eod    ecd    cnt
        tbl.push_back(mk(0, 16'h8000, 0, 1, 8'h11, 0, 16'h0000, 0, 16'h0000, 8'h00, 8'h00, 8'h00, 0));
        tbl.push_back(mk(0, 16'h8001, 0, 1, 8'h22, 0, 16'h0000, 0, 16'h0000, 8'h00, 8'h00, 8'h00, 0));
        tbl.push_back(mk(0, 16'h9FFF, 0, 1, 8'h33, 0, 16'h0000, 0, 16'h0000, 8'h00, 8'h00, 8'h00, 0));
        tbl.push_back(mk(1, 16'hFE9F, 0, 1, 8'h5A, 0, 16'h0000, 0, 16'h0000, 8'h00, 8'h00, 8'h00, 0));
        tbl.push_back(mk(1, 16'hFE10, 0, 1, 8'h3C, 0, 16'h0000, 0, 16'h0000, 8'h00, 8'h00, 8'h00, 0));
        tbl.push_back(mk(0, 16'h8010, 0, 1, 8'h77, 0, 16'h0000, 0, 16'h0000, 8'h00, 8'h00, 8'h00, 0));
        tbl.push_back(mk(0, 16'h8100, 0, 1, 8'h01, 0, 16'h0000, 0, 16'h0000, 8'h00, 8'h00, 8'h00, 0));
        tbl.push_back(mk(0, 16'h8000, 1, 0, 8'h00, 0, 16'h0000, 0, 16'h0000, 8'h00, 8'h00, 8'h11, 0));
        tbl.push_back(mk(1, 16'h9FFF, 1, 0, 8'h00, 1, 16'h8001, 1, 16'hFE9F, 8'h22, 8'h5A, 8'h33, 0));
        tbl.push_back(mk(2, 16'hFE9F, 1, 0, 8'h00, 1, 16'hA000, 1, 16'hFEA0, 8'hFF, 8'hFF, 8'hFF, 0));
        tbl.push_back(mk(3, 16'h8010, 0, 1, 8'hAA, 1, 16'h8010, 0, 16'h0000, 8'h77, 8'h00, 8'h00, 1));
        tbl.push_back(mk(3, 16'hFE10, 0, 1, 8'hAA, 0, 16'h0000, 1, 16'hFE10, 8'h00, 8'h3C, 8'h00, 2));
        tbl.push_back(mk(3, 16'h8010, 1, 0, 8'h00, 0, 16'h0000, 0, 16'h0000, 8'h00, 8'h00, 8'hFF, 2));
        tbl.push_back(mk(0, 16'h8010, 1, 0, 8'h00, 0, 16'h0000, 0, 16'h0000, 8'h00, 8'h00, 8'h77, 2));
        tbl.push_back(mk(2, 16'h8010, 1, 0, 8'h00, 0, 16'h0000, 0, 16'h0000, 8'h00, 8'h00, 8'h77, 2));
        tbl.push_back(mk(0, 16'hFE10, 1, 0, 8'h00, 0, 16'h0000, 0, 16'h0000, 8'h00, 8'h00, 8'h3C, 2));
        tbl.push_back(mk(2, 16'hFE10, 0, 1, 8'hBB, 0, 16'h0000, 0, 16'h0000, 8'h00, 8'h00, 8'h00, 3));
        tbl.push_back(mk(0, 16'hFE10, 1, 0, 8'h00, 0, 16'h0000, 0, 16'h0000, 8'h00, 8'h00, 8'h3C, 3));
        tbl.push_back(mk(3, 16'hC000, 0, 1, 8'h12, 0, 16'h0000, 0, 16'h0000, 8'h00, 8'h00, 8'h00, 3));
        tbl.push_back(mk(0, 16'hC000, 1, 0, 8'h00, 0, 16'h0000, 0, 16'h0000, 8'h00, 8'h00, 8'hFF, 3));
        tbl.push_back(mk(0, 16'hFEA0, 0, 1, 8'h99, 0, 16'h0000, 0, 16'h0000, 8'h00, 8'h00, 8'h00, 3));
        tbl.push_back(mk(0, 16'hFEA0, 1, 0, 8'h00, 0, 16'h0000, 0, 16'h0000, 8'h00, 8'h00, 8'hFF, 3));
        tbl.push_back(mk(1, 16'h8000, 1, 0, 8'h00, 1, 16'h0000, 0, 16'h0000, 8'hFF, 8'h00, 8'h11, 3));

        foreach (tbl[i]) apply(i, tbl[i]);

        // Back-to-back PPU fetches: three consecutive pulses, in order.
        seq_a[0] = 16'h8000; seq_a[1] = 16'h8001; seq_a[2] = 16'h9FFF;
        seq_d[0] = 8'h11;    seq_d[1] = 8'h22;    seq_d[2] = 8'h33;
        mode_in = 2'd0;
        for (int c = 0; c < L + 4; c++) begin
            ppu_addr_valid_in = (c < 3);
            if (c < 3) ppu_addr_in = seq_a[c];
            step();
            chk($sformatf("burst c%0d ppu_valid", c), 32'(ppu_data_valid_out),
                32'(c >= L && c < L + 3));
            if (c >= L && c < L + 3)
                chk($sformatf("burst c%0d ppu_data", c), 32'(ppu_data_out), 32'(seq_d[c-L]));
        end
        idle();

        // Read-first: CPU write and PPU read of $8100 in the same cycle.
        seq_d[0] = 8'h01; seq_d[1] = 8'h02;
        for (int c = 0; c < L + 3; c++) begin
            ppu_addr_valid_in = (c < 2);
            ppu_addr_in = 16'h8100;
            cpu_wr_in = (c == 0); cpu_addr_in = 16'h8100; cpu_data_in = 8'h02;
            step();
            chk($sformatf("collide c%0d ppu_valid", c), 32'(ppu_data_valid_out),
                32'(c >= L && c < L + 2));
            if (c >= L && c < L + 2)
                chk($sformatf("collide c%0d ppu_data", c), 32'(ppu_data_out), 32'(seq_d[c-L]));
        end
        idle();

        // Reset with two requests in flight: nothing may come out afterwards.
        ppu_addr_valid_in = 1'b1; ppu_addr_in = 16'h8000;
        oam_addr_valid_in = 1'b1; oam_addr_in = 16'hFE9F;
        step();
        step();
        idle();
        #2 rst_in = 1'b0;
        #1;
        chk_valids("midrst", 1'b0, 1'b0, 1'b0);
        chk("midrst ppu_data", 32'(ppu_data_out), 32'h0);
        chk("midrst oam_data", 32'(oam_data_out), 32'h0);
        chk("midrst blocked_cnt", 32'(blocked_wr_count_out), 32'h0);
        step();
        step();
        #2 rst_in = 1'b1;
        for (int c = 0; c < L + 3; c++) begin
            step();
            chk_valids($sformatf("postrst c%0d", c), 1'b0, 1'b0, 1'b0);
        end
        apply(100, mk(0, 16'h8001, 1, 0, 8'h00, 1, 16'h8100, 1, 16'hFE9F, 8'h02, 8'h5A, 8'h22, 0));

        // Read and write strobes together: write lands, no read response.
        apply(101, mk(0, 16'h8200, 1, 1, 8'h5C, 0, 16'h0000, 0, 16'h0000, 8'h00, 8'h00, 8'h00, 0));
        apply(102, mk(0, 16'h8200, 1, 0, 8'h00, 0, 16'h0000, 0, 16'h0000, 8'h00, 8'h00, 8'h5C, 0));

        // Counter saturation: 65540 locked writes in mode 3.
        mode_in = 2'd3; cpu_addr_in = 16'h8000; cpu_data_in = 8'hEE; cpu_wr_in = 1'b1;
        repeat (65534) step();
        chk("sat near", 32'(blocked_wr_count_out), 32'hFFFE);
        step();
        chk("sat reach", 32'(blocked_wr_count_out), 32'hFFFF);
        repeat (5) step();
        chk("sat hold", 32'(blocked_wr_count_out), 32'hFFFF);
        idle();
        apply(103, mk(0, 16'h8000, 1, 0, 8'h00, 0, 16'h0000, 0, 16'h0000, 8'h00, 8'h00, 8'h11, 16'hFFFF));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
